// File: rtl/xy_route_unit.sv
// xy_route_unit: own X/Y coordinate register plus a registered one-hot dimension-order
// (XY or YX) output-port decision with valid/ready handshakes and a saturating header counter.
module xy_route_unit #(
    parameter int X_BITS   = 4,
    parameter int Y_BITS   = 4,
    parameter int YX_ORDER = 0,
    parameter int CNT_BITS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       addr_we,
    input  logic [X_BITS+Y_BITS-1:0]   addr_in,
    output logic [X_BITS+Y_BITS-1:0]   addr_out,
    input  logic                       hdr_valid,
    input  logic [X_BITS+Y_BITS-1:0]   hdr_dest,
    output logic                       hdr_ready,
    output logic                       route_valid,
    output logic [4:0]                 route_port,
    input  logic                       route_ready,
    output logic [CNT_BITS-1:0]        route_cnt
);
    logic [X_BITS-1:0] dx, ox;
    logic [Y_BITS-1:0] dy, oy;
    logic [4:0] x_port, y_port, first, second, port;
    logic accept;

    assign dx = hdr_dest[X_BITS-1:0];
    assign dy = hdr_dest[X_BITS+Y_BITS-1:X_BITS];
    assign ox = addr_out[X_BITS-1:0];
    assign oy = addr_out[X_BITS+Y_BITS-1:X_BITS];
    assign hdr_ready = !route_valid || route_ready;
    assign accept = hdr_valid && hdr_ready;

    // Each dimension yields zero when already aligned, so the first non-zero one wins.
    always_comb begin
        x_port = (dx > ox) ? 5'b00010 : (dx < ox) ? 5'b00100 : 5'b00000;
        y_port = (dy > oy) ? 5'b01000 : (dy < oy) ? 5'b10000 : 5'b00000;
        first  = (YX_ORDER != 0) ? y_port : x_port;
        second = (YX_ORDER != 0) ? x_port : y_port;
        port   = (|first) ? first : (|second) ? second : 5'b00001;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_out    <= '0;
            route_valid <= 1'b0;
            route_port  <= 5'b00000;
            route_cnt   <= '0;
        end else begin
            if (addr_we)
                addr_out <= addr_in;
            if (accept) begin
                route_valid <= 1'b1;
                route_port  <= port;
                if (route_cnt != '1)
                    route_cnt <= route_cnt + CNT_BITS'(1);
            end else if (route_ready) begin
                route_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_xy_route_unit.sv
// tb_xy_route_unit: two instances (XY/8-bit counter and YX/2-bit counter) on shared stimulus,
// checked every cycle against a coordinate-level reference model plus literal test-plan values.
module tb_xy_route_unit;
    logic clk = 0;
    logic reset = 1;
    logic addr_we = 0, hdr_valid = 0, route_ready = 0;
    logic [7:0] addr_in = 0, hdr_dest = 0;
    logic [7:0] addr0, addr1;
    logic rdy0, rdy1, val0, val1;
    logic [4:0] port0, port1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    int tests = 0, failed = 0;

    logic [7:0] m_addr;
    logic m_valid;
    logic [4:0] m_p0, m_p1;
    int m_cnt;

    always #5 clk = ~clk;

    xy_route_unit #(.X_BITS(4), .Y_BITS(4), .YX_ORDER(0), .CNT_BITS(8)) dut0 (
        .clk(clk), .reset(reset), .addr_we(addr_we), .addr_in(addr_in), .addr_out(addr0),
        .hdr_valid(hdr_valid), .hdr_dest(hdr_dest), .hdr_ready(rdy0), .route_valid(val0),
        .route_port(port0), .route_ready(route_ready), .route_cnt(cnt0));

    xy_route_unit #(.X_BITS(4), .Y_BITS(4), .YX_ORDER(1), .CNT_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .addr_we(addr_we), .addr_in(addr_in), .addr_out(addr1),
        .hdr_valid(hdr_valid), .hdr_dest(hdr_dest), .hdr_ready(rdy1), .route_valid(val1),
        .route_port(port1), .route_ready(route_ready), .route_cnt(cnt1));

    function automatic logic [4:0] route(input logic [7:0] d, input logic [7:0] o, input bit yx);
        int dx, dy, ox, oy;
        dx = d & 15; dy = d >> 4; ox = o & 15; oy = o >> 4;
        if (yx && dy != oy) return (dy > oy) ? 5'b01000 : 5'b10000;
        if (dx != ox) return (dx > ox) ? 5'b00010 : 5'b00100;
        if (dy != oy) return (dy > oy) ? 5'b01000 : 5'b10000;
        return 5'b00001;
    endfunction

    function automatic int sat(input int n, input int lim);
        return (n > lim) ? lim : n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state as described by the handshake and routing rules.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_addr <= 0; m_valid <= 0; m_p0 <= 0; m_p1 <= 0; m_cnt <= 0;
        end else begin
            if (hdr_valid && (!m_valid || route_ready)) begin
                m_valid <= 1;
                m_p0 <= route(hdr_dest, m_addr, 0);
                m_p1 <= route(hdr_dest, m_addr, 1);
                m_cnt <= m_cnt + 1;
            end else if (route_ready) m_valid <= 0;
            if (addr_we) m_addr <= addr_in;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("hdr_ready0", rdy0, !m_valid || route_ready);
            chk("hdr_ready1", rdy1, !m_valid || route_ready);
            chk("route_valid0", val0, m_valid);
            chk("route_valid1", val1, m_valid);
            chk("addr_out0", addr0, m_addr);
            chk("addr_out1", addr1, m_addr);
            chk("route_cnt0", cnt0, sat(m_cnt, 255));
            chk("route_cnt1", cnt1, sat(m_cnt, 3));
            if (m_valid) begin
                chk("route_port0", port0, m_p0);
                chk("route_port1", port1, m_p1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [7:0] hdrs [5] = '{8'h35, 8'h31, 8'h53, 8'h13, 8'h33};
        logic [4:0] exp_p [5] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        logic [1:0] exp_c [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        tick(); tick();
        reset = 0;
        addr_we = 1; addr_in = 8'h33;
        tick();
        addr_we = 0;
        chk("lit_addr", addr0, 8'h33);
        route_ready = 1;
        for (int i = 0; i < 5; i++) begin
            hdr_valid = 1; hdr_dest = hdrs[i];
            tick();
            chk("lit_seq_port", port0, exp_p[i]);
            chk("lit_sat_cnt", cnt1, exp_c[i]);
        end
        chk("lit_cnt5", cnt0, 8'd5);
        hdr_dest = 8'h55;
        tick();
        chk("lit_xy_55", port0, 5'b00010);
        chk("lit_yx_55", port1, 5'b01000);
        hdr_valid = 0;
        tick();
        hdr_valid = 1; hdr_dest = 8'h35;
        tick();
        route_ready = 0; hdr_dest = 8'h31;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lit_stall_ready", rdy0, 1'b0);
            chk("lit_stall_port", port0, 5'b00010);
            tick();
        end
        route_ready = 1;
        tick();
        chk("lit_stall_release", port0, 5'b00100);
        hdr_valid = 0;
        tick();
        addr_we = 1; addr_in = 8'h55; hdr_valid = 1; hdr_dest = 8'h44;
        tick();
        addr_we = 0;
        chk("lit_old_addr", port0, 5'b00010);
        tick();
        chk("lit_new_addr", port0, 5'b00100);
        hdr_valid = 0;
        tick();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            hdr_valid = $urandom_range(0, 3) != 0;
            hdr_dest = 8'($urandom);
            route_ready = $urandom_range(0, 3) != 0;
            addr_we = $urandom_range(0, 15) == 0;
            addr_in = 8'($urandom);
            tick();
        end
        reset = 0; addr_we = 0;
        hdr_valid = 1; hdr_dest = 8'h12; route_ready = 0;
        tick();
        chk("lit_pre_reset_valid", val0, 1'b1);
        reset = 1;
        #1;
        chk("lit_rst_valid", val0, 1'b0);
        chk("lit_rst_cnt", cnt0, 8'd0);
        chk("lit_rst_addr", addr0, 8'h00);
        chk("lit_rst_ready", rdy0, 1'b1);
        tick();
        reset = 0; hdr_valid = 0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
